// File: rtl/password_entry_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : password_entry_fsm
//  Description : Keypad password controller. Collects four BCD digits,
//                shows them calculator-style (filling from the right) on four
//                display nibbles, compares them with a fixed code, and drives
//                unlocked / error / lockout flags with timed hold periods.
//                Unused display positions carry 4'hF, which the downstream
//                7-segment decoder blanks.
//
//  Ports       : clk         in   1  system clock, rising edge
//                rst_n       in   1  synchronous reset, active-low
//                key_valid   in   1  one-cycle strobe, key_digit valid
//                key_digit   in   4  keypad value, only 0..9 accepted
//                key_clear   in   1  one-cycle strobe, abort current entry
//                digit3..0   out  4  display nibbles, digit3 leftmost
//                unlocked    out  1  high while the code was accepted
//                error       out  1  high while a wrong code is reported
//                locked_out  out  1  high during the lockout period
//                fail_count  out  2  consecutive-failure count (saturating)
//
//  Revision    : 1.0  initial release
// ============================================================================
module password_entry_fsm #(
    parameter logic [15:0] PASSWORD    = 16'h1234,
    parameter int unsigned SHOW_CYCLES = 50_000_000,
    parameter int unsigned LOCK_CYCLES = 250_000_000,
    parameter int unsigned MAX_FAILS   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       key_clear,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       unlocked,
    output logic       error,
    output logic       locked_out,
    output logic [1:0] fail_count
);

    localparam int unsigned c_MAX_CYCLES = (SHOW_CYCLES > LOCK_CYCLES) ? SHOW_CYCLES : LOCK_CYCLES;
    localparam int          c_TIMER_W    = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_TIMER_W-1:0] c_SHOW_LAST = c_TIMER_W'(SHOW_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_LOCK_LAST = c_TIMER_W'(LOCK_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE = c_TIMER_W'(1);
    localparam logic [15:0]          c_BLANK     = 16'hFFFF;

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_ENTRY    = 3'd1;
    localparam logic [2:0] c_S_CHECK    = 3'd2;
    localparam logic [2:0] c_S_UNLOCKED = 3'd3;
    localparam logic [2:0] c_S_ERROR    = 3'd4;
    localparam logic [2:0] c_S_LOCKOUT  = 3'd5;

    logic [2:0]           r_state;
    logic [15:0]          r_buf;
    logic [2:0]           r_cnt;
    logic [c_TIMER_W-1:0] r_timer;
    logic [1:0]           r_fail;

    logic [2:0]           w_state_nx;
    logic [15:0]          w_buf_nx;
    logic [2:0]           w_cnt_nx;
    logic [c_TIMER_W-1:0] w_timer_nx;
    logic [1:0]           w_fail_nx;

    logic                 w_entry_phase;
    logic                 w_timed_phase;
    logic                 w_key_ok;
    logic                 w_clear;
    logic [2:0]           w_fail_inc;
    logic [1:0]           w_fail_sat;
    logic                 w_show_buf;

    // Keys and clears are only honoured while a code is being collected.
    assign w_entry_phase = (r_state == c_S_IDLE) || (r_state == c_S_ENTRY);
    assign w_timed_phase = (r_state == c_S_UNLOCKED) || (r_state == c_S_ERROR) ||
                           (r_state == c_S_LOCKOUT);
    assign w_key_ok      = w_entry_phase && key_valid && (key_digit <= 4'd9);
    assign w_clear       = w_entry_phase && key_clear;

    // One extra bit so the increment can be compared against MAX_FAILS
    // before being clamped into the 2-bit output.
    assign w_fail_inc    = {1'b0, r_fail} + 3'd1;
    assign w_fail_sat    = w_fail_inc[2] ? 2'd3 : w_fail_inc[1:0];

    always_comb begin
        w_state_nx = r_state;
        w_buf_nx   = r_buf;
        w_cnt_nx   = r_cnt;
        w_fail_nx  = r_fail;

        case (r_state)
            c_S_IDLE, c_S_ENTRY: begin
                // Clear has priority over a simultaneous key.
                if (w_clear) begin
                    w_state_nx = c_S_IDLE;
                    w_buf_nx   = c_BLANK;
                    w_cnt_nx   = 3'd0;
                end else if (w_key_ok) begin
                    w_buf_nx   = {r_buf[11:0], key_digit};
                    w_cnt_nx   = r_cnt + 3'd1;
                    w_state_nx = (r_cnt == 3'd3) ? c_S_CHECK : c_S_ENTRY;
                end
            end

            c_S_CHECK: begin
                if (r_buf == PASSWORD) begin
                    w_fail_nx  = 2'd0;
                    w_state_nx = c_S_UNLOCKED;
                end else begin
                    w_fail_nx  = w_fail_sat;
                    w_state_nx = (32'(w_fail_inc) >= MAX_FAILS) ? c_S_LOCKOUT : c_S_ERROR;
                end
            end

            c_S_UNLOCKED, c_S_ERROR: begin
                if (r_timer == c_SHOW_LAST) begin
                    w_state_nx = c_S_IDLE;
                    w_buf_nx   = c_BLANK;
                    w_cnt_nx   = 3'd0;
                end
            end

            c_S_LOCKOUT: begin
                if (r_timer == c_LOCK_LAST) begin
                    w_state_nx = c_S_IDLE;
                    w_buf_nx   = c_BLANK;
                    w_cnt_nx   = 3'd0;
                    w_fail_nx  = 2'd0;
                end
            end

            default: begin
                w_state_nx = c_S_IDLE;
                w_buf_nx   = c_BLANK;
                w_cnt_nx   = 3'd0;
            end
        endcase

        // Timer restarts on every state change and only runs in the held states.
        w_timer_nx = '0;
        if (w_timed_phase && (w_state_nx == r_state)) begin
            w_timer_nx = r_timer + c_TIMER_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
            r_buf   <= c_BLANK;
            r_cnt   <= 3'd0;
            r_timer <= '0;
            r_fail  <= 2'd0;
        end else begin
            r_state <= w_state_nx;
            r_buf   <= w_buf_nx;
            r_cnt   <= w_cnt_nx;
            r_timer <= w_timer_nx;
            r_fail  <= w_fail_nx;
        end
    end

    // Moore outputs, decoded from registered state only.
    assign w_show_buf = w_entry_phase || (r_state == c_S_CHECK);

    always_comb begin
        {digit3, digit2, digit1, digit0} = c_BLANK;
        if (w_show_buf) begin
            {digit3, digit2, digit1, digit0} = r_buf;
        end
    end

    assign unlocked   = (r_state == c_S_UNLOCKED);
    assign error      = (r_state == c_S_ERROR);
    assign locked_out = (r_state == c_S_LOCKOUT);
    assign fail_count = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_password_entry_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_password_entry_fsm
//  Description : Self-checking bench for password_entry_fsm. A reference model
//                tracks the entered digits, the current phase and a countdown
//                of remaining hold cycles; each driven cycle pushes the
//                expected outputs into a scoreboard queue that a separate
//                monitor pops and compares on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_password_entry_fsm;

    localparam int          c_SHOW = 4;
    localparam int          c_LOCK = 8;
    localparam int          c_MAXF = 3;
    localparam logic [15:0] c_PW   = 16'h1234;

    localparam int c_P_COLLECT = 0;
    localparam int c_P_CHECK   = 1;
    localparam int c_P_OPEN    = 2;
    localparam int c_P_REJECT  = 3;
    localparam int c_P_LOCK    = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       key_clear;
    logic [3:0] digit3, digit2, digit1, digit0;
    logic       unlocked, error, locked_out;
    logic [1:0] fail_count;

    always #5 clk = ~clk;

    password_entry_fsm #(
        .PASSWORD    (c_PW),
        .SHOW_CYCLES (c_SHOW),
        .LOCK_CYCLES (c_LOCK),
        .MAX_FAILS   (c_MAXF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .key_clear  (key_clear),
        .digit3     (digit3),
        .digit2     (digit2),
        .digit1     (digit1),
        .digit0     (digit0),
        .unlocked   (unlocked),
        .error      (error),
        .locked_out (locked_out),
        .fail_count (fail_count)
    );

    typedef struct {
        logic [15:0] dig;
        logic        u;
        logic        e;
        logic        l;
        logic [1:0]  fc;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int m_digits[$];
    int m_phase = c_P_COLLECT;
    int m_left  = 0;
    int m_fails = 0;

    function automatic void model_step(bit rn, bit v, logic [3:0] d, bit c);
        int code;
        if (!rn) begin
            m_digits.delete();
            m_phase = c_P_COLLECT;
            m_left  = 0;
            m_fails = 0;
            return;
        end
        case (m_phase)
            c_P_COLLECT: begin
                if (c) begin
                    m_digits.delete();
                end else if (v && (d <= 4'd9)) begin
                    m_digits.push_back(int'(d));
                    if (m_digits.size() == 4) m_phase = c_P_CHECK;
                end
            end
            c_P_CHECK: begin
                code = 0;
                foreach (m_digits[i]) code = code * 16 + m_digits[i];
                if (code == int'(c_PW)) begin
                    m_fails = 0;
                    m_phase = c_P_OPEN;
                    m_left  = c_SHOW;
                end else begin
                    m_fails = m_fails + 1;
                    if (m_fails >= c_MAXF) begin
                        m_phase = c_P_LOCK;
                        m_left  = c_LOCK;
                    end else begin
                        m_phase = c_P_REJECT;
                        m_left  = c_SHOW;
                    end
                end
            end
            default: begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (m_phase == c_P_LOCK) m_fails = 0;
                    m_phase = c_P_COLLECT;
                    m_digits.delete();
                end
            end
        endcase
    endfunction

    function automatic exp_t model_expect(string tag);
        exp_t e;
        int   n;
        e.dig = 16'hFFFF;
        n     = m_digits.size();
        if (m_phase == c_P_COLLECT || m_phase == c_P_CHECK) begin
            // Most recent digit sits in the rightmost position.
            for (int i = 0; i < n; i++) e.dig[4*(n-1-i) +: 4] = 4'(m_digits[i]);
        end
        e.u   = (m_phase == c_P_OPEN);
        e.e   = (m_phase == c_P_REJECT);
        e.l   = (m_phase == c_P_LOCK);
        e.fc  = 2'(m_fails);
        e.tag = tag;
        return e;
    endfunction

    task automatic step(bit rn, bit v, logic [3:0] d, bit c, string tag);
        @(negedge clk);
        #1;
        rst_n     = rn;
        key_valid = v;
        key_digit = d;
        key_clear = c;
        model_step(rn, v, d, c);
        sb.push_back(model_expect(tag));
    endtask

    task automatic key(logic [3:0] d, string tag);
        step(1'b1, 1'b1, d, 1'b0, tag);
    endtask

    task automatic idle(int n, string tag);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, 1'b0, tag);
    endtask

    task automatic code4(logic [15:0] c, string tag);
        logic [15:0] v;
        v = c;
        for (int i = 3; i >= 0; i--) key(v[4*i +: 4], tag);
    endtask

    // Monitor: one comparison per scoreboard entry, on the falling edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if ({digit3, digit2, digit1, digit0} !== e.dig || unlocked !== e.u ||
                    error !== e.e || locked_out !== e.l || fail_count !== e.fc) begin
                    bad++;
                    $display("FAIL %s @%0t: got dig=%h u=%b e=%b l=%b fc=%0d, want dig=%h u=%b e=%b l=%b fc=%0d",
                             e.tag, $time, {digit3, digit2, digit1, digit0}, unlocked, error,
                             locked_out, fail_count, e.dig, e.u, e.e, e.l, e.fc);
                end
            end
        end
    end

    initial begin : stim
        logic [15:0] pw;
        logic [3:0]  d;
        bit          rn, v, c;
        pw        = c_PW;
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_digit = 4'd0;
        key_clear = 1'b0;

        // Reset held two cycles
        step(1'b0, 1'b0, 4'd0, 1'b0, "reset");
        step(1'b0, 1'b0, 4'd0, 1'b0, "reset");
        idle(2, "idle_after_reset");

        // Correct code, full unlock period and return to idle
        code4(16'h1234, "good_entry");
        idle(8, "good_hold");

        // One wrong code, then the correct one clears the failure count
        code4(16'h1235, "wrong_entry");
        idle(7, "error_hold");
        code4(16'h1234, "good_after_err");
        idle(7, "unlock_hold");

        // Three wrong codes in a row lead to lockout; keys ignored meanwhile
        code4(16'h9999, "wrong1");
        idle(6, "wrong1_hold");
        code4(16'h0000, "wrong2");
        idle(6, "wrong2_hold");
        code4(16'h4321, "wrong3");
        key(4'd1, "lock_key");
        key(4'd2, "lock_key");
        step(1'b1, 1'b0, 4'd0, 1'b1, "lock_clear");
        idle(8, "lock_hold");

        // Clear beats a simultaneous key; non-BCD key ignored
        code4(16'h1235, "pre_clear_fail");
        idle(6, "pre_clear_hold");
        key(4'd7, "clear_seq");
        key(4'd8, "clear_seq");
        step(1'b1, 1'b1, 4'd9, 1'b1, "clear_and_key");
        key(4'hA, "non_bcd");
        key(4'hF, "non_bcd");
        key(4'd5, "after_clear");
        step(1'b1, 1'b0, 4'd0, 1'b1, "clear_only");
        idle(2, "idle");

        // Reset in the second unlocked cycle
        code4(16'h1234, "good_then_rst");
        idle(2, "unlock_cycles");
        step(1'b0, 1'b0, 4'd0, 1'b0, "rst_mid_unlock");
        idle(3, "after_rst");

        // Randomised traffic biased towards the correct digits
        for (int i = 0; i < 1500; i++) begin
            rn = ($urandom_range(0, 199) != 0);
            v  = ($urandom_range(0, 99) < 45);
            c  = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 2) != 0)
                d = pw[4*(3 - (m_digits.size() % 4)) +: 4];
            else
                d = 4'($urandom_range(0, 15));
            step(rn, v, d, c, "random");
        end
        idle(12, "final_idle");

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #2;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
